// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_pkg
// Description : Shared constants for the RV32I data-memory responder. It holds
//               the funct3 encodings, the responder FSM state encoding, and an
//               access-legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM encoding
    localparam int         STATE_W  = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // An access is an error when funct3 is not legal for its direction, or
    // when a halfword or word access is not naturally aligned. The unsigned
    // encodings exist only for loads.
    function automatic logic accessErr(input logic       isWrite,
                                       input logic [2:0] f3,
                                       input logic [1:0] addrLo);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = addrLo[0];
            F3_W:    err = |addrLo;
            F3_BU:   err = isWrite;
            F3_HU:   err = isWrite | addrLo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Word-organised data storage. It has per-byte write enables and
//               a registered read port. The contents are never reset.
// Ports       : clk          rising-edge clock
//               i_byteEn     byte-lane write enables (lane 0 = bits 7:0)
//               i_wordAddr   word index
//               i_writeData  lane-positioned write data
//               i_readEn     capture the addressed word into o_readData
//               o_readData   registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int WORD_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic [3:0]             i_byteEn,
    input  logic [WORD_ADDR_W-1:0] i_wordAddr,
    input  logic [31:0]            i_writeData,
    input  logic                   i_readEn,
    output logic [31:0]            o_readData
);

    localparam int c_DEPTH = 1 << WORD_ADDR_W;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_readData;

    // A read and a write in the same cycle return the old word. The
    // responder never reads a word back in its own store cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_byteEn[i]) begin
                r_mem[i_wordAddr][8*i +: 8] <= i_writeData[8*i +: 8];
            end
        end
        if (i_readEn) begin
            r_readData <= r_mem[i_wordAddr];
        end
    end

    assign o_readData = r_readData;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : RV32I data-memory responder. It uses valid/ready request and
//               response channels and returns one response per accepted
//               request. It handles byte/half/word lane steering, load
//               extension, and misalignment / illegal-funct3 detection.
// Ports       : clk, reset (async, active-low)
//               req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata
//               resp_valid/resp_ready/resp_rdata/resp_err/resp_write
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_write
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_nextState;

    logic        w_accept;
    logic        w_reqErr;
    logic [3:0]  w_byteEn;
    logic [31:0] w_bankWdata;
    logic [31:0] w_rdWord;

    logic        r_reqWrite;
    logic        r_reqErr;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addrLo;

    logic [7:0]  w_lane8;
    logic [15:0] w_lane16;
    logic [31:0] w_loadData;

    logic [31:0] r_respRdata;
    logic        r_respErr;
    logic        r_respWrite;

    assign w_accept = req_valid && req_ready;
    assign w_reqErr = accessErr(req_write, req_funct3, req_addr[1:0]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_nextState = S_ACCESS;
            S_ACCESS: w_nextState = S_RESP;
            S_RESP: begin
                if (w_accept) begin
                    w_nextState = S_ACCESS;
                end else if (resp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default:  w_nextState = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // req_ready is gated by reset, so nothing is accepted and nothing is
    // written while reset is held low.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: req_ready = reset;
            S_RESP: begin
                resp_valid = 1'b1;
                req_ready  = reset && resp_ready;
            end
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // ---------------- Store lane steering ----------------
    // The data is replicated across all lanes. The byte enables choose
    // which lanes are written.
    always_comb begin
        w_byteEn    = 4'b0000;
        w_bankWdata = req_wdata;
        case (req_funct3)
            F3_B: begin
                w_byteEn    = 4'b0001 << req_addr[1:0];
                w_bankWdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                w_byteEn    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_bankWdata = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                w_byteEn    = 4'b1111;
                w_bankWdata = req_wdata;
            end
            default: begin
                w_byteEn    = 4'b0000;
                w_bankWdata = req_wdata;
            end
        endcase
        if (!(w_accept && req_write && !w_reqErr)) begin
            w_byteEn = 4'b0000;
        end
    end

    dmem_bank #(
        .WORD_ADDR_W (ADDR_W - 2)
    ) u_bank (
        .clk         (clk),
        .i_byteEn    (w_byteEn),
        .i_wordAddr  (req_addr[ADDR_W-1:2]),
        .i_writeData (w_bankWdata),
        .i_readEn    (w_accept && !req_write),
        .o_readData  (w_rdWord)
    );

    // ---------------- Request capture ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reqWrite <= 1'b0;
            r_reqErr   <= 1'b0;
            r_funct3   <= 3'b000;
            r_addrLo   <= 2'b00;
        end else if (w_accept) begin
            r_reqWrite <= req_write;
            r_reqErr   <= w_reqErr;
            r_funct3   <= req_funct3;
            r_addrLo   <= req_addr[1:0];
        end
    end

    // ---------------- Load lane select and extension ----------------
    always_comb begin
        case (r_addrLo)
            2'd0:    w_lane8 = w_rdWord[7:0];
            2'd1:    w_lane8 = w_rdWord[15:8];
            2'd2:    w_lane8 = w_rdWord[23:16];
            default: w_lane8 = w_rdWord[31:24];
        endcase
        w_lane16   = r_addrLo[1] ? w_rdWord[31:16] : w_rdWord[15:0];
        w_loadData = 32'h0000_0000;
        if (!r_reqErr && !r_reqWrite) begin
            case (r_funct3)
                F3_B:    w_loadData = {{24{w_lane8[7]}}, w_lane8};
                F3_H:    w_loadData = {{16{w_lane16[15]}}, w_lane16};
                F3_W:    w_loadData = w_rdWord;
                F3_BU:   w_loadData = {24'h000000, w_lane8};
                F3_HU:   w_loadData = {16'h0000, w_lane16};
                default: w_loadData = 32'h0000_0000;
            endcase
        end
    end

    // ---------------- Response registers ----------------
    // The response registers load only in ACCESS. This keeps them stable
    // for as long as the consumer stalls in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_respRdata <= 32'h0000_0000;
            r_respErr   <= 1'b0;
            r_respWrite <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_respRdata <= w_loadData;
            r_respErr   <= r_reqErr;
            r_respWrite <= r_reqWrite;
        end
    end

    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;
    assign resp_write = r_respWrite;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A byte-level memory
//               model predicts every response. A compare process checks each
//               visible response against that prediction, and directed steps
//               pin latency and literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              resp_write;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_write (resp_write)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        write;
    } resp_t;

    resp_t      expQ[$];
    logic [7:0] mMem [0:(1<<ADDR_W)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    function automatic logic modelErr(input logic w, input logic [2:0] f3, input int a);
        int size;
        if (w) begin
            if (f3 == 3'b000) size = 1;
            else if (f3 == 3'b001) size = 2;
            else if (f3 == 3'b010) size = 4;
            else return 1'b1;
        end else begin
            if (f3 == 3'b000 || f3 == 3'b100) size = 1;
            else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
            else if (f3 == 3'b010) size = 4;
            else return 1'b1;
        end
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int a);
        int b;
        int h;
        b = mMem[a];
        h = (a % 2 == 0) ? (mMem[a+1] * 256 + mMem[a]) : 0;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b101:  return 32'(h);
            default: return {mMem[a+3], mMem[a+2], mMem[a+1], mMem[a]};
        endcase
    endfunction

    task automatic modelAccept(input logic w, input logic [2:0] f3, input int a, input logic [31:0] wd);
        resp_t r;
        int    n;
        r.err   = modelErr(w, f3, a);
        r.write = w;
        r.rdata = 32'h0;
        if (!r.err) begin
            if (w) begin
                n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
                for (int i = 0; i < n; i++) mMem[a+i] = wd[8*i +: 8];
            end else begin
                r.rdata = modelLoad(f3, a);
            end
        end
        expQ.push_back(r);
    endtask

    // ---------------- Compare process ----------------
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (expQ.size() == 0) begin
                check("cmp_stray_resp", 32'(resp_valid), 32'h0);
            end else begin
                check("cmp_rdata", resp_rdata, expQ[0].rdata);
                check("cmp_err",   32'(resp_err),   32'(expQ[0].err));
                check("cmp_write", 32'(resp_write), 32'(expQ[0].write));
            end
        end
    end

    always @(posedge clk) begin
        if (reset && resp_valid && resp_ready && expQ.size() > 0) begin
            void'(expQ.pop_front());
        end
    end

    always @(negedge reset) expQ.delete();

    // ---------------- Stimulus helpers ----------------
    task automatic issue(input logic w, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, output int edges);
        logic acc;
        acc        = 1'b0;
        edges      = 0;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            acc = req_ready;
            @(posedge clk);
            edges++;
            if (acc) begin
                modelAccept(w, f3, int'(a), wd);
                break;
            end
        end
        if (!acc) check("accept_timeout", 32'h0, 32'h1);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitResp(input string name, input logic [31:0] expR, input logic expE, input logic expW);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_latency"}, 32'(n), 32'd2);
        if (seen) begin
            check({name, "_rdata"}, resp_rdata, expR);
            check({name, "_err"},   32'(resp_err),   32'(expE));
            check({name, "_write"}, 32'(resp_write), 32'(expW));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence ----------------
    initial begin
        int          e;
        logic [31:0] holdR;
        logic        holdE;
        logic        holdW;

        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;

        #3;
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        check("reset_resp_err",   32'(resp_err),   32'h0);
        check("reset_resp_write", 32'(resp_write), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("idle_req_ready", 32'(req_ready), 32'h1);

        issue(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, e);
        waitResp("sw_010", 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        waitResp("lw_010", 32'hDEADBEEF, 1'b0, 1'b0);
        issue(1'b0, 3'b000, 10'h013, 32'h0, e);
        waitResp("lb_013", 32'hFFFFFFDE, 1'b0, 1'b0);
        issue(1'b0, 3'b100, 10'h013, 32'h0, e);
        waitResp("lbu_013", 32'h000000DE, 1'b0, 1'b0);
        issue(1'b0, 3'b001, 10'h012, 32'h0, e);
        waitResp("lh_012", 32'hFFFFDEAD, 1'b0, 1'b0);
        issue(1'b0, 3'b101, 10'h012, 32'h0, e);
        waitResp("lhu_012", 32'h0000DEAD, 1'b0, 1'b0);

        // Errors
        issue(1'b1, 3'b001, 10'h011, 32'h00001234, e);
        waitResp("sh_misaligned", 32'h0, 1'b1, 1'b1);
        issue(1'b0, 3'b011, 10'h010, 32'h0, e);
        waitResp("ld_f3_011", 32'h0, 1'b1, 1'b0);
        issue(1'b1, 3'b010, 10'h012, 32'h11111111, e);
        waitResp("sw_misaligned", 32'h0, 1'b1, 1'b1);
        issue(1'b1, 3'b100, 10'h010, 32'h22222222, e);
        waitResp("st_f3_100", 32'h0, 1'b1, 1'b1);
        issue(1'b0, 3'b001, 10'h011, 32'h0, e);
        waitResp("lh_misaligned", 32'h0, 1'b1, 1'b0);
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        waitResp("lw_after_err", 32'hDEADBEEF, 1'b0, 1'b0);

        // Store then back-to-back load of the same word
        issue(1'b1, 3'b000, 10'h011, 32'h000000AB, e);
        waitResp("sb_011", 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        check("b2b_accept_edges", 32'(e), 32'd1);
        waitResp("lw_b2b", 32'hDEADABEF, 1'b0, 1'b0);

        issue(1'b1, 3'b001, 10'h012, 32'hFFFF5678, e);
        waitResp("sh_012", 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b101, 10'h012, 32'h0, e);
        waitResp("lhu_012b", 32'h00005678, 1'b0, 1'b0);
        issue(1'b0, 3'b000, 10'h010, 32'h0, e);
        waitResp("lb_010", 32'hFFFFFFEF, 1'b0, 1'b0);
        issue(1'b0, 3'b001, 10'h010, 32'h0, e);
        waitResp("lh_010", 32'hFFFFABEF, 1'b0, 1'b0);

        // Backpressure: hold the response, then release with a new request
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        resp_ready = 1'b0;
        waitResp("lw_bp", 32'h5678ABEF, 1'b0, 1'b0);
        holdR      = resp_rdata;
        holdE      = resp_err;
        holdW      = resp_write;
        req_write  = 1'b0;
        req_funct3 = 3'b100;
        req_addr   = 10'h011;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid), 32'h1);
            check("bp_rdata_stable", resp_rdata, holdR);
            check("bp_err_stable", 32'(resp_err), 32'(holdE));
            check("bp_write_stable", 32'(resp_write), 32'(holdW));
            check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        issue(1'b0, 3'b100, 10'h011, 32'h0, e);
        check("bp_release_accept_edges", 32'(e), 32'd1);
        waitResp("lbu_011", 32'h000000AB, 1'b0, 1'b0);

        // Reset during ACCESS
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        #2 reset = 1'b0;
        #1;
        check("rst_resp_valid_async", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release_req_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(resp_valid), 32'h0);
        end
        issue(1'b0, 3'b010, 10'h010, 32'h0, e);
        waitResp("lw_after_reset", 32'h5678ABEF, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
